// File: rtl/alu_writeback.sv
// ALU writeback stage: conditional execution, flag register, one-entry
// writeback buffer toward the register file, and a retired-instruction counter.
module alu_writeback #(
    parameter int WordWidth = 32
) (
    input  logic                 in_Clk,
    input  logic                 in_Rst,
    input  logic                 in_Valid,
    output logic                 out_Ready,
    input  logic [WordWidth-1:0] in_Y,
    input  logic [3:0]           in_CNZV,
    input  logic [3:0]           in_Opcode,
    input  logic [3:0]           in_Cond,
    input  logic                 in_SetFlags,
    input  logic [3:0]           in_Rd,
    input  logic                 in_Flush,
    input  logic                 in_WbReady,
    output logic                 out_WbValid,
    output logic [3:0]           out_WbRd,
    output logic [WordWidth-1:0] out_WbData,
    output logic [3:0]           out_CNZV,
    output logic                 out_Carry,
    output logic [15:0]          out_RetireCnt,
    output logic                 out_DbgState
);

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    state_t state, state_next;

    logic flag_c, flag_n, flag_z, flag_v;
    logic cond_pass;
    logic is_compare;
    logic accept;
    logic retire;
    logic load_wb;
    logic load_flags;

    // Handshakes: a transfer happens on a rising edge where valid && ready.
    // Upstream: in_Valid/out_Ready; ready never looks at valid. Downstream:
    // out_WbValid/in_WbReady; contents hold stable while valid && !ready.
    assign out_Ready = !in_Flush && ((state == EMPTY) || in_WbReady);
    assign accept    = in_Valid && out_Ready;

    assign flag_c = out_CNZV[3];
    assign flag_n = out_CNZV[2];
    assign flag_z = out_CNZV[1];
    assign flag_v = out_CNZV[0];

    always_comb begin
        cond_pass = 1'b0;
        case (in_Cond)
            4'h0:    cond_pass = flag_z;
            4'h1:    cond_pass = !flag_z;
            4'h2:    cond_pass = flag_c;
            4'h3:    cond_pass = !flag_c;
            4'h4:    cond_pass = flag_n;
            4'h5:    cond_pass = !flag_n;
            4'h6:    cond_pass = flag_v;
            4'h7:    cond_pass = !flag_v;
            4'h8:    cond_pass = flag_c && !flag_z;
            4'h9:    cond_pass = !flag_c || flag_z;
            4'hA:    cond_pass = (flag_n == flag_v);
            4'hB:    cond_pass = (flag_n != flag_v);
            4'hC:    cond_pass = !flag_z && (flag_n == flag_v);
            4'hD:    cond_pass = flag_z || (flag_n != flag_v);
            4'hE:    cond_pass = 1'b1;
            default: cond_pass = 1'b0;
        endcase
    end

    // TST/TEQ/CMP/CMN (8..B) only update flags and never write a register.
    assign is_compare = (in_Opcode[3:2] == 2'b10);
    assign retire     = accept && cond_pass;
    assign load_wb    = retire && !is_compare;
    assign load_flags = retire && (in_SetFlags || is_compare);

    always_comb begin
        state_next = state;
        if (in_Flush) begin
            state_next = EMPTY;
        end else if (load_wb) begin
            state_next = FULL;
        end else if ((state == FULL) && in_WbReady) begin
            state_next = EMPTY;
        end
    end

    always_ff @(posedge in_Clk) begin
        if (in_Rst) begin
            state <= EMPTY;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge in_Clk) begin
        if (in_Rst) begin
            out_WbRd      <= '0;
            out_WbData    <= '0;
            out_CNZV      <= '0;
            out_RetireCnt <= '0;
        end else begin
            if (load_wb) begin
                out_WbRd   <= in_Rd;
                out_WbData <= in_Y;
            end
            if (load_flags) begin
                out_CNZV <= in_CNZV;
            end
            if (retire) begin
                out_RetireCnt <= out_RetireCnt + 16'd1;
            end
        end
    end

    assign out_WbValid  = (state == FULL);
    assign out_Carry    = out_CNZV[3];
    assign out_DbgState = state;

endmodule

// File: tb/tb_alu_writeback.sv
// Directed bench for alu_writeback: vector table with hand-computed results,
// a writeback scoreboard, and hand-written reset, wrap and never sequences.
module tb_alu_writeback;

    logic        in_Clk;
    logic        in_Rst;
    logic        in_Valid;
    logic        out_Ready;
    logic [31:0] in_Y;
    logic [3:0]  in_CNZV;
    logic [3:0]  in_Opcode;
    logic [3:0]  in_Cond;
    logic        in_SetFlags;
    logic [3:0]  in_Rd;
    logic        in_Flush;
    logic        in_WbReady;
    logic        out_WbValid;
    logic [3:0]  out_WbRd;
    logic [31:0] out_WbData;
    logic [3:0]  out_CNZV;
    logic        out_Carry;
    logic [15:0] out_RetireCnt;
    logic        out_DbgState;

    alu_writeback #(.WordWidth(32)) dut (
        .in_Clk       (in_Clk),
        .in_Rst       (in_Rst),
        .in_Valid     (in_Valid),
        .out_Ready    (out_Ready),
        .in_Y         (in_Y),
        .in_CNZV      (in_CNZV),
        .in_Opcode    (in_Opcode),
        .in_Cond      (in_Cond),
        .in_SetFlags  (in_SetFlags),
        .in_Rd        (in_Rd),
        .in_Flush     (in_Flush),
        .in_WbReady   (in_WbReady),
        .out_WbValid  (out_WbValid),
        .out_WbRd     (out_WbRd),
        .out_WbData   (out_WbData),
        .out_CNZV     (out_CNZV),
        .out_Carry    (out_Carry),
        .out_RetireCnt(out_RetireCnt),
        .out_DbgState (out_DbgState)
    );

    // clock / reset
    initial begin
        in_Clk = 1'b0;
        forever #5 in_Clk = ~in_Clk;
    end

    typedef struct {
        logic        rst, valid, s, flush, wbr;
        logic [3:0]  op, cond, rd, cnzv;
        logic [31:0] y;
        logic        e_rdy, e_wbv, c_data;
        logic [3:0]  e_rd, e_flags;
        logic [31:0] e_data;
        logic [15:0] e_cnt;
    } vec_t;

    vec_t        tbl[$];
    logic [35:0] exp_q[$];
    int          checks = 0;
    int          passes = 0;
    logic        sb_en  = 1'b0;
    logic        prev_wbv;
    logic [3:0]  prev_rd;
    logic [31:0] prev_data;

    function automatic vec_t mk(
        input logic rst, valid, input logic [3:0] op, cond, input logic s,
        input logic [3:0] rd, input logic [31:0] y, input logic [3:0] cnzv,
        input logic flush, wbr, input logic e_rdy, e_wbv, c_data,
        input logic [3:0] e_rd, input logic [31:0] e_data,
        input logic [3:0] e_flags, input logic [15:0] e_cnt);
        vec_t v;
        v.rst = rst; v.valid = valid; v.op = op; v.cond = cond; v.s = s;
        v.rd = rd; v.y = y; v.cnzv = cnzv; v.flush = flush; v.wbr = wbr;
        v.e_rdy = e_rdy; v.e_wbv = e_wbv; v.c_data = c_data; v.e_rd = e_rd;
        v.e_data = e_data; v.e_flags = e_flags; v.e_cnt = e_cnt;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %0h, want %0h", name, act, exp);
    endtask

    // driver
    task automatic drive(input vec_t v);
        in_Rst = v.rst; in_Valid = v.valid; in_Opcode = v.op; in_Cond = v.cond;
        in_SetFlags = v.s; in_Rd = v.rd; in_Y = v.y; in_CNZV = v.cnzv;
        in_Flush = v.flush; in_WbReady = v.wbr;
    endtask

    task automatic check_regs(input string tag, input logic e_wbv, input logic [3:0] e_flags,
                              input logic [15:0] e_cnt);
        check({tag, " wb_valid"}, {31'd0, out_WbValid}, {31'd0, e_wbv});
        check({tag, " flags"}, {28'd0, out_CNZV}, {28'd0, e_flags});
        check({tag, " carry"}, {31'd0, out_Carry}, {31'd0, e_flags[3]});
        check({tag, " retire_cnt"}, {16'd0, out_RetireCnt}, {16'd0, e_cnt});
    endtask

    // scoreboard: every register-file transfer must match the queue head
    always @(posedge in_Clk) begin
        if (sb_en && !in_Rst && !in_Flush && out_WbValid && in_WbReady) begin
            checks++;
            if (exp_q.size() == 0) begin
                $display("FAIL sb_unexpected: got rd=%0h data=%0h, want no transfer",
                         out_WbRd, out_WbData);
            end else begin
                logic [35:0] e;
                e = exp_q.pop_front();
                if ({out_WbRd, out_WbData} === e) passes++;
                else $display("FAIL sb_transfer: got %0h, want %0h", {out_WbRd, out_WbData}, e);
            end
        end
    end

    initial begin
        vec_t idle;
        idle = mk(0, 0, 4'h0, 4'hE, 0, 4'h0, 32'h0, 4'h0, 0, 0, 0, 0, 0, 4'h0, 32'h0, 4'h0, 16'd0);

        // rst valid op cond s rd y cnzv flush wbr | rdy wbv cdata rd data flags cnt
        tbl.push_back(mk(0,1,4'h4,4'hE,0,4'h1,32'h5,4'h0,0,0, 1,1,1,4'h1,32'h5,4'h0,16'd1));
        tbl.push_back(mk(0,0,4'h0,4'hE,0,4'h0,32'h0,4'h0,0,0, 0,1,1,4'h1,32'h5,4'h0,16'd1));
        tbl.push_back(mk(1,1,4'h4,4'hE,0,4'h1,32'h9,4'h0,0,0, 0,0,1,4'h0,32'h0,4'h0,16'd0));
        tbl.push_back(mk(0,1,4'hA,4'hE,0,4'h0,32'h0,4'h2,0,1, 1,0,0,4'h0,32'h0,4'h2,16'd1));
        tbl.push_back(mk(0,1,4'hD,4'h0,0,4'h2,32'h7,4'hF,0,1, 1,1,1,4'h2,32'h7,4'h2,16'd2));
        tbl.push_back(mk(0,1,4'hD,4'h1,0,4'h5,32'h8,4'h0,0,1, 1,0,0,4'h0,32'h0,4'h2,16'd2));
        tbl.push_back(mk(0,1,4'h2,4'hE,1,4'h3,32'hFFFFFFFF,4'h4,0,1, 1,1,1,4'h3,32'hFFFFFFFF,4'h4,16'd3));
        for (int k = 0; k < 3; k++)
            tbl.push_back(mk(0,1,4'h4,4'hE,0,4'h6,32'h1,4'h0,0,0, 0,1,1,4'h3,32'hFFFFFFFF,4'h4,16'd3));
        tbl.push_back(mk(0,0,4'h0,4'hE,0,4'h0,32'h0,4'h0,0,1, 1,0,0,4'h0,32'h0,4'h4,16'd3));
        tbl.push_back(mk(1,0,4'h0,4'hE,0,4'h0,32'h0,4'h0,0,0, 1,0,1,4'h0,32'h0,4'h0,16'd0));
        for (int k = 0; k < 4; k++)
            tbl.push_back(mk(0,1,4'h4,4'hE,0,4'(8+k),32'(16+k),4'h0,0,1,
                             1,1,1,4'(8+k),32'(16+k),4'h0,16'(k+1)));
        tbl.push_back(mk(0,0,4'h0,4'hE,0,4'h0,32'h0,4'h0,0,1, 1,0,0,4'h0,32'h0,4'h0,16'd4));
        tbl.push_back(mk(0,1,4'hC,4'hE,1,4'h4,32'hAA,4'h8,0,0, 1,1,1,4'h4,32'hAA,4'h8,16'd5));
        tbl.push_back(mk(0,1,4'h4,4'hE,1,4'h7,32'h1,4'h1,1,0, 0,0,0,4'h0,32'h0,4'h8,16'd5));
        tbl.push_back(mk(0,1,4'h4,4'hE,0,4'h7,32'h77,4'h0,0,1, 1,1,1,4'h7,32'h77,4'h8,16'd6));
        tbl.push_back(mk(0,1,4'hD,4'h8,0,4'h1,32'h1,4'h0,0,1, 1,1,1,4'h1,32'h1,4'h8,16'd7));
        tbl.push_back(mk(0,1,4'hD,4'h9,0,4'h2,32'h2,4'h0,0,1, 1,0,0,4'h0,32'h0,4'h8,16'd7));
        tbl.push_back(mk(0,1,4'hB,4'hE,0,4'h0,32'h0,4'h5,0,1, 1,0,0,4'h0,32'h0,4'h5,16'd8));
        tbl.push_back(mk(0,1,4'hD,4'hA,0,4'h3,32'h3,4'h0,0,1, 1,1,1,4'h3,32'h3,4'h5,16'd9));
        tbl.push_back(mk(0,1,4'hD,4'hB,1,4'h4,32'h4,4'hF,0,1, 1,0,0,4'h0,32'h0,4'h5,16'd9));
        tbl.push_back(mk(0,1,4'hD,4'hC,0,4'h5,32'h5,4'h0,0,1, 1,1,1,4'h5,32'h5,4'h5,16'd10));
        tbl.push_back(mk(0,1,4'h8,4'hF,1,4'h0,32'h0,4'h2,0,1, 1,0,0,4'h0,32'h0,4'h5,16'd10));

        // initial reset
        drive(idle);
        in_Rst = 1'b1;
        repeat (2) @(posedge in_Clk);
        #1;
        check("reset wb_rd", {28'd0, out_WbRd}, 32'd0);
        check("reset wb_data", out_WbData, 32'd0);
        check_regs("reset", 1'b0, 4'h0, 16'd0);

        prev_wbv = 1'b0; prev_rd = '0; prev_data = '0;
        sb_en = 1'b1;
        foreach (tbl[i]) begin
            string tag;
            tag = $sformatf("vec%0d", i);
            @(negedge in_Clk);
            drive(tbl[i]);
            if (!tbl[i].rst && !tbl[i].flush && tbl[i].wbr && prev_wbv)
                exp_q.push_back({prev_rd, prev_data});
            #1;
            check({tag, " ready"}, {31'd0, out_Ready}, {31'd0, tbl[i].e_rdy});
            @(posedge in_Clk);
            #1;
            check_regs(tag, tbl[i].e_wbv, tbl[i].e_flags, tbl[i].e_cnt);
            if (tbl[i].c_data) begin
                check({tag, " wb_rd"}, {28'd0, out_WbRd}, {28'd0, tbl[i].e_rd});
                check({tag, " wb_data"}, out_WbData, tbl[i].e_data);
            end
            prev_wbv = tbl[i].e_wbv; prev_rd = tbl[i].e_rd; prev_data = tbl[i].e_data;
        end
        @(negedge in_Clk);
        sb_en = 1'b0;
        drive(idle);
        check("sb leftover", exp_q.size(), 32'd0);

        // retire counter wrap, then a never-condition op
        in_Rst = 1'b1;
        @(negedge in_Clk);
        drive(idle);
        in_Valid = 1'b1; in_Opcode = 4'hD; in_Rd = 4'h9; in_Y = 32'h1234; in_WbReady = 1'b1;
        repeat (65535) @(posedge in_Clk);
        #1;
        check("wrap cnt ffff", {16'd0, out_RetireCnt}, 32'h0000FFFF);
        @(posedge in_Clk);
        #1;
        check_regs("wrap", 1'b1, 4'h0, 16'd0);
        @(negedge in_Clk);
        in_Opcode = 4'h8; in_Cond = 4'hF; in_SetFlags = 1'b1; in_CNZV = 4'hF;
        @(posedge in_Clk);
        #1;
        check_regs("never", 1'b0, 4'h0, 16'd0);

        // reset while stalled full, with an op offered in the reset cycle
        @(negedge in_Clk);
        drive(idle);
        in_Valid = 1'b1; in_Opcode = 4'h4; in_Rd = 4'h1; in_Y = 32'h5;
        @(negedge in_Clk);
        in_Valid = 1'b0;
        @(negedge in_Clk);
        check("stall wb_valid", {31'd0, out_WbValid}, 32'd1);
        in_Rst = 1'b1; in_Valid = 1'b1; in_SetFlags = 1'b1; in_CNZV = 4'hF;
        @(posedge in_Clk);
        #1;
        check_regs("rst_stall", 1'b0, 4'h0, 16'd0);
        check("rst_stall state", {31'd0, out_DbgState}, 32'd0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/alu_writeback.md
ALU_WRITEBACK -- requirements
Module: alu_writeback

Interface
REQ-001 Parameter WordWidth, default 32: data path width, shared with the ALU.
REQ-002 Port in_Clk, input, 1: the single clock; all state updates on its rising edge.
REQ-003 Port in_Rst, input, 1: reset, synchronous and active-high.
REQ-004 Port in_Valid, input, 1: upstream holds a valid ALU result this cycle.
REQ-005 Port out_Ready, output, 1: block accepts the upstream result this cycle.
REQ-006 Port in_Y, input, WordWidth: ALU result.
REQ-007 Port in_CNZV, input, 4: ALU flags, bit3=C, bit2=N, bit1=Z, bit0=V.
REQ-008 Port in_Opcode, input, 4: ALU opcode. Encoding: AND=0, EOR=1, SUB=2, RSB=3, ADD=4, ADC=5, SBC=6, RSC=7, TST=8, TEQ=9, CMP=A, CMN=B, ORR=C, MOV=D, BIC=E, MVN=F.
REQ-009 Port in_Cond, input, 4: condition field, ARM encoding 0x0 EQ through 0xE AL; 0xF means never.
REQ-010 Port in_SetFlags, input, 1: S bit.
REQ-011 Port in_Rd, input, 4: destination register index.
REQ-012 Port in_Flush, input, 1: kill the pending writeback and any same-cycle accept.
REQ-013 Port in_WbReady, input, 1: register file accepts the writeback this cycle.
REQ-014 Port out_WbValid, output, 1: writeback pending.
REQ-015 Port out_WbRd, output, 4: writeback register index.
REQ-016 Port out_WbData, output, WordWidth: writeback data.
REQ-017 Port out_CNZV, output, 4: architectural flag register, same bit order as in_CNZV.
REQ-018 Port out_Carry, output, 1: equals out_CNZV[3]; drives the ALU carry input.
REQ-019 Port out_RetireCnt, output, 16: count of accepted instructions whose condition passed.

Function
REQ-020 The block SHALL hold a one-entry writeback buffer with two states, EMPTY and FULL; out_WbValid SHALL be 1 exactly when the state is FULL.
REQ-021 out_Ready SHALL equal !in_Flush && (EMPTY || in_WbReady). This is combinational, with no dependency on in_Valid.
REQ-022 Accept SHALL occur when in_Valid && out_Ready.
REQ-023 CondPass SHALL be evaluated combinationally from in_Cond and the current out_CNZV. EQ tests Z; NE tests !Z; CS tests C; CC tests !C; MI tests N; PL tests !N; VS tests V; VC tests !V; HI is C&&!Z; LS is !C||Z; GE is N==V; LT is N!=V; GT is !Z&&N==V; LE is Z||N!=V; AL is 1; 0xF is 0.
REQ-024 On accept with CondPass, out_CNZV SHALL load in_CNZV in either case: in_SetFlags=1, or opcode is 8..B (TST/TEQ/CMP/CMN set flags regardless of S). Otherwise flags SHALL be unchanged.
REQ-025 On accept with CondPass and opcode not 8..B, the buffer SHALL load in_Rd and in_Y and go FULL on the next cycle.
REQ-026 On accept with a failed condition, or with opcode 8..B, no writeback SHALL be produced.
REQ-027 When FULL and in_WbReady=1 with no new writeback loaded, the state SHALL go to EMPTY next cycle. When a new writeback loads in the same cycle, it SHALL stay FULL with the new contents, giving full throughput.
REQ-028 When FULL and in_WbReady=0, out_WbRd and out_WbData SHALL hold stable.
REQ-029 in_Flush=1 SHALL set the state to EMPTY next cycle. It SHALL block acceptance that cycle. It SHALL NOT alter out_CNZV, and it SHALL NOT undo flags set by earlier accepts.
REQ-030 out_RetireCnt SHALL increment by 1 on each accept with CondPass and wrap from 0xFFFF to 0x0000.
REQ-031 Flags written by an accept SHALL be visible to CondPass of an accept on the very next cycle; there SHALL be no extra flag latency.
REQ-032 Writeback latency SHALL be one cycle: data accepted at edge N is on out_WbData after edge N.

Reset
REQ-033 While in_Rst=1 at a clock edge, the state SHALL become EMPTY. out_WbValid, out_WbRd, out_WbData, out_CNZV, out_Carry and out_RetireCnt SHALL all become 0.
REQ-034 in_Rst SHALL take priority over accept and flush, including mid-stall while FULL. No accept or flag update SHALL occur in a reset cycle.

Verification
REQ-035 Reset check: ADD R1=5 stalled with in_WbReady=0, then in_Rst pulse. Required: out_WbValid=0, out_CNZV=0, out_RetireCnt=0.
REQ-036 Flag-set compare: CMP with in_CNZV=0b0010 and cond AL. Required: no writeback, out_CNZV=0b0010. Next-cycle MOVEQ R2=7 writes R2=7. MOVNE instead produces no writeback and out_RetireCnt is unchanged.
REQ-037 Stall handling: SUBS R3=0xFFFFFFFF with CNZV=0b0100 accepted, then in_WbReady=0 for 3 cycles. Required: out_WbValid=1 and out_WbData held. out_Ready=0 throughout. out_CNZV=0b0100 from the cycle after accept.
REQ-038 Back-to-back throughput: 4 consecutive ADDs with in_WbReady=1. Required: 4 writebacks on 4 consecutive cycles, out_RetireCnt=4.
REQ-039 Flush: pending ORR R4, with in_Flush=1 and in_Valid=1 in the same cycle. Required: out_WbValid=0 next cycle, the new op is not accepted, out_CNZV is unchanged.
REQ-040 Wrap and never: drive 0x10000 AL ops. Required: out_RetireCnt=0. Then an op with in_Cond=0xF and in_SetFlags=1 leaves flags and count unchanged.
